// File: rtl/airlock_sequencer.sv
// Airlock sequencer: runs the vent/door/pressurize phases for rover arrival or departure,
// launching an external seconds counter at the start of every phase.
module airlock_sequencer #(
    parameter logic [9:0] T_VENT  = 10'd8,
    parameter logic [9:0] T_DOOR  = 10'd5,
    parameter logic [9:0] T_PRESS = 10'd10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       arrive,
    input  logic       depart,
    input  logic       timer_done,
    output logic       timer_start,
    output logic [9:0] timer_seconds,
    output logic       outer_open,
    output logic       inner_open,
    output logic       vent_on,
    output logic       pump_on,
    output logic       busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_VENT  = 3'd1;
    localparam logic [2:0] S_OUTER = 3'd2;
    localparam logic [2:0] S_PRESS = 3'd3;
    localparam logic [2:0] S_INNER = 3'd4;

    localparam logic DIR_ARRIVE = 1'b0;
    localparam logic DIR_DEPART = 1'b1;

    logic [2:0] state_q, state_d;
    logic       dir_q, dir_d;
    logic       first_q, first_d;
    logic       last_q, last_d;
    logic       pend_a_q, pend_a_d;
    logic       pend_d_q, pend_d_d;

    // Arrive: VENT->OUTER->PRESS->INNER->IDLE; depart: INNER->VENT->OUTER->PRESS->IDLE.
    function automatic logic [2:0] next_phase(input logic [2:0] s, input logic d);
        case (s)
            S_VENT:  next_phase = S_OUTER;
            S_OUTER: next_phase = S_PRESS;
            S_PRESS: next_phase = (d == DIR_DEPART) ? S_IDLE : S_INNER;
            S_INNER: next_phase = (d == DIR_DEPART) ? S_VENT : S_IDLE;
            default: next_phase = S_IDLE;
        endcase
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d  = state_q;
        dir_d    = dir_q;
        first_d  = 1'b0;
        last_d   = last_q;
        pend_a_d = pend_a_q | arrive;
        pend_d_d = pend_d_q | depart;

        if (state_q == S_IDLE) begin
            // Arrive wins unless depart is also pending and arrive was served last.
            if (pend_a_d && (!pend_d_d || last_q == DIR_DEPART)) begin
                state_d  = S_VENT;
                dir_d    = DIR_ARRIVE;
                last_d   = DIR_ARRIVE;
                pend_a_d = 1'b0;
                first_d  = 1'b1;
            end else if (pend_d_d) begin
                state_d  = S_INNER;
                dir_d    = DIR_DEPART;
                last_d   = DIR_DEPART;
                pend_d_d = 1'b0;
                first_d  = 1'b1;
            end
        end else if (!first_q && timer_done) begin
            state_d = next_phase(state_q, dir_q);
            first_d = (state_d != S_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values.
        if (reset) begin
            state_q  <= S_IDLE;
            dir_q    <= DIR_ARRIVE;
            first_q  <= 1'b0;
            last_q   <= DIR_DEPART;
            pend_a_q <= 1'b0;
            pend_d_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            first_q  <= first_d;
            last_q   <= last_d;
            pend_a_q <= pend_a_d;
            pend_d_q <= pend_d_d;
        end
    end

    // Actuators decode straight from the state, so only one can ever be active.
    always_comb begin
        outer_open    = 1'b0;
        inner_open    = 1'b0;
        vent_on       = 1'b0;
        pump_on       = 1'b0;
        timer_seconds = 10'd0;
        case (state_q)
            S_VENT:  vent_on    = 1'b1;
            S_OUTER: outer_open = 1'b1;
            S_PRESS: pump_on    = 1'b1;
            S_INNER: inner_open = 1'b1;
            default: ;
        endcase
        if (first_q) begin
            case (state_q)
                S_VENT:          timer_seconds = T_VENT;
                S_OUTER, S_INNER: timer_seconds = T_DOOR;
                S_PRESS:         timer_seconds = T_PRESS;
                default:         timer_seconds = 10'd0;
            endcase
        end
    end

    assign timer_start = first_q && (state_q != S_IDLE);
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_airlock_sequencer.sv
// Directed bench for airlock_sequencer: phase order, timer loads, arbitration and reset behaviour.
module tb_airlock_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       arrive = 1'b0;
    logic       depart = 1'b0;
    logic       timer_done = 1'b0;
    logic       timer_start;
    logic [9:0] timer_seconds;
    logic       outer_open, inner_open, vent_on, pump_on, busy;

    int checks = 0;
    int errors = 0;

    // Recorded by run_seq for each sequence.
    int       seq_secs[$];
    bit [3:0] seq_acts[$];  // {outer, inner, vent, pump} on each timer_start cycle
    int       busy_cycles;
    int       viol;
    bit       timed_out;

    localparam bit [3:0] A_OUTER = 4'b1000;
    localparam bit [3:0] A_INNER = 4'b0100;
    localparam bit [3:0] A_VENT  = 4'b0010;
    localparam bit [3:0] A_PUMP  = 4'b0001;

    airlock_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .arrive       (arrive),
        .depart       (depart),
        .timer_done   (timer_done),
        .timer_start  (timer_start),
        .timer_seconds(timer_seconds),
        .outer_open   (outer_open),
        .inner_open   (inner_open),
        .vent_on      (vent_on),
        .pump_on      (pump_on),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] all_outs();
        return {timer_start, timer_seconds, outer_open, inner_open, vent_on, pump_on, busy};
    endfunction

    // Steps through one sequence from its first phase cycle until busy drops.
    task automatic run_seq(input bit hold_done, input int dep1, input int dep2);
        int  cnt;
        bit  armed;
        seq_secs.delete();
        seq_acts.delete();
        busy_cycles = 0;
        viol = 0;
        timed_out = 0;
        armed = 0;
        cnt = 0;
        for (int cyc = 0; ; cyc++) begin
            if (cyc >= 200) begin
                timed_out = 1;
                break;
            end
            if (!busy) break;
            busy_cycles++;
            if (hold_done) timer_done = 1'b1;
            else begin
                timer_done = 1'b0;
                if (armed) begin
                    cnt--;
                    if (cnt == 0) begin
                        timer_done = 1'b1;
                        armed = 0;
                    end
                end
            end
            if (timer_start) begin
                seq_secs.push_back(int'(timer_seconds));
                seq_acts.push_back({outer_open, inner_open, vent_on, pump_on});
                armed = 1;
                cnt = 3;
            end
            if (outer_open && inner_open) viol++;
            if ($countones({outer_open, inner_open, vent_on, pump_on}) > 1) viol++;
            depart = (cyc == dep1 || cyc == dep2);
            tick();
        end
        timer_done = 1'b0;
        depart = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        arrive = 1'b1;
        depart = 1'b1;
        tick();
        reset = 1'b0;
        arrive = 1'b0;
        depart = 1'b0;
        checks++;
        if (all_outs() !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0000", all_outs());
        end
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || timer_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_discard: busy=%b timer_start=%b expected 0 0", busy, timer_start);
        end
    endtask

    task automatic test_arrive();
        int exp_s[4] = '{8, 5, 10, 5};
        bit [3:0] exp_a[4] = '{A_VENT, A_OUTER, A_PUMP, A_INNER};
        arrive = 1'b1;
        tick();
        arrive = 1'b0;
        checks++;
        if (timer_start !== 1'b1 || timer_seconds !== 10'd8 || vent_on !== 1'b1) begin
            errors++;
            $display("FAIL arrive_latency: start=%b secs=%0d vent=%b expected 1 8 1",
                     timer_start, timer_seconds, vent_on);
        end
        run_seq(1'b0, -1, -1);
        checks++;
        if (timed_out || seq_secs.size() != 4 || busy_cycles != 16 || viol != 0) begin
            errors++;
            $display("FAIL arrive_shape: timeout=%b phases=%0d busy=%0d viol=%0d expected 0 4 16 0",
                     timed_out, seq_secs.size(), busy_cycles, viol);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (seq_secs[i] != exp_s[i] || seq_acts[i] != exp_a[i]) begin
                errors++;
                $display("FAIL arrive_phase%0d: secs=%0d act=%b expected %0d %b",
                         i, seq_secs[i], seq_acts[i], exp_s[i], exp_a[i]);
            end
        end
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || timer_start !== 1'b0) begin
            errors++;
            $display("FAIL arrive_idle: busy=%b start=%b expected 0 0", busy, timer_start);
        end
    endtask

    task automatic test_depart();
        int exp_s[4] = '{5, 8, 5, 10};
        bit [3:0] exp_a[4] = '{A_INNER, A_VENT, A_OUTER, A_PUMP};
        depart = 1'b1;
        tick();
        depart = 1'b0;
        run_seq(1'b0, -1, -1);
        checks++;
        if (timed_out || seq_secs.size() != 4 || busy_cycles != 16 || viol != 0) begin
            errors++;
            $display("FAIL depart_shape: timeout=%b phases=%0d busy=%0d viol=%0d expected 0 4 16 0",
                     timed_out, seq_secs.size(), busy_cycles, viol);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (seq_secs[i] != exp_s[i] || seq_acts[i] != exp_a[i]) begin
                errors++;
                $display("FAIL depart_phase%0d: secs=%0d act=%b expected %0d %b",
                         i, seq_secs[i], seq_acts[i], exp_s[i], exp_a[i]);
            end
        end
    endtask

    task automatic test_both();
        apply_reset();
        arrive = 1'b1;
        depart = 1'b1;
        tick();
        arrive = 1'b0;
        depart = 1'b0;
        checks++;
        if (vent_on !== 1'b1 || timer_seconds !== 10'd8) begin
            errors++;
            $display("FAIL both_arrive_first: vent=%b secs=%0d expected 1 8", vent_on, timer_seconds);
        end
        run_seq(1'b0, -1, -1);
        checks++;
        if (timed_out || seq_secs.size() != 4 || busy !== 1'b0) begin
            errors++;
            $display("FAIL both_arrive_seq: timeout=%b phases=%0d busy=%b expected 0 4 0",
                     timed_out, seq_secs.size(), busy);
        end
        tick();
        checks++;
        if (timer_start !== 1'b1 || timer_seconds !== 10'd5 || inner_open !== 1'b1) begin
            errors++;
            $display("FAIL both_depart_next: start=%b secs=%0d inner=%b expected 1 5 1",
                     timer_start, timer_seconds, inner_open);
        end
        run_seq(1'b0, -1, -1);
        checks++;
        if (timed_out || seq_secs.size() != 4 || seq_secs[0] != 5 || seq_secs[3] != 10) begin
            errors++;
            $display("FAIL both_depart_seq: timeout=%b phases=%0d first=%0d last=%0d expected 0 4 5 10",
                     timed_out, seq_secs.size(), seq_secs[0], seq_secs[3]);
        end
    endtask

    task automatic test_done_held();
        int exp_s[4] = '{8, 5, 10, 5};
        arrive = 1'b1;
        tick();
        arrive = 1'b0;
        run_seq(1'b1, -1, -1);
        checks++;
        if (timed_out || seq_secs.size() != 4 || busy_cycles != 8 || viol != 0) begin
            errors++;
            $display("FAIL held_shape: timeout=%b phases=%0d busy=%0d viol=%0d expected 0 4 8 0",
                     timed_out, seq_secs.size(), busy_cycles, viol);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (seq_secs[i] != exp_s[i]) begin
                errors++;
                $display("FAIL held_phase%0d: secs=%0d expected %0d", i, seq_secs[i], exp_s[i]);
            end
        end
    endtask

    // Arrive was served last, so a simultaneous pair must go depart first.
    task automatic test_alternate();
        arrive = 1'b1;
        depart = 1'b1;
        tick();
        arrive = 1'b0;
        depart = 1'b0;
        checks++;
        if (inner_open !== 1'b1 || timer_seconds !== 10'd5) begin
            errors++;
            $display("FAIL alt_depart_first: inner=%b secs=%0d expected 1 5", inner_open, timer_seconds);
        end
        run_seq(1'b1, -1, -1);
        tick();
        checks++;
        if (vent_on !== 1'b1 || timer_seconds !== 10'd8 || timer_start !== 1'b1) begin
            errors++;
            $display("FAIL alt_arrive_second: vent=%b secs=%0d start=%b expected 1 8 1",
                     vent_on, timer_seconds, timer_start);
        end
        run_seq(1'b1, -1, -1);
        checks++;
        if (timed_out || seq_secs.size() != 4 || viol != 0) begin
            errors++;
            $display("FAIL alt_arrive_seq: timeout=%b phases=%0d viol=%0d expected 0 4 0",
                     timed_out, seq_secs.size(), viol);
        end
    endtask

    task automatic test_reset_mid();
        int starts = 0;
        int busys = 0;
        arrive = 1'b1;
        tick();
        arrive = 1'b0;
        tick();
        tick();
        tick();
        timer_done = 1'b1;
        tick();
        timer_done = 1'b0;
        checks++;
        if (outer_open !== 1'b1 || timer_start !== 1'b1 || timer_seconds !== 10'd5) begin
            errors++;
            $display("FAIL mid_outer: outer=%b start=%b secs=%0d expected 1 1 5",
                     outer_open, timer_start, timer_seconds);
        end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (all_outs() !== 16'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %h expected 0000", all_outs());
        end
        for (int i = 0; i < 12; i++) begin
            timer_done = i[0];
            tick();
            if (timer_start) starts++;
            if (busy) busys++;
        end
        timer_done = 1'b0;
        checks++;
        if (starts != 0 || busys != 0) begin
            errors++;
            $display("FAIL mid_no_resume: starts=%0d busy_cycles=%0d expected 0 0", starts, busys);
        end
    endtask

    task automatic test_depart_dup();
        int exp_s[4] = '{5, 8, 5, 10};
        int extra = 0;
        arrive = 1'b1;
        tick();
        arrive = 1'b0;
        run_seq(1'b0, 2, 9);
        checks++;
        if (timed_out || seq_secs.size() != 4 || seq_secs[0] != 8) begin
            errors++;
            $display("FAIL dup_arrive_seq: timeout=%b phases=%0d first=%0d expected 0 4 8",
                     timed_out, seq_secs.size(), seq_secs[0]);
        end
        tick();
        run_seq(1'b0, -1, -1);
        checks++;
        if (timed_out || seq_secs.size() != 4) begin
            errors++;
            $display("FAIL dup_depart_seq: timeout=%b phases=%0d expected 0 4", timed_out, seq_secs.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (seq_secs[i] != exp_s[i]) begin
                errors++;
                $display("FAIL dup_phase%0d: secs=%0d expected %0d", i, seq_secs[i], exp_s[i]);
            end
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy || timer_start) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL dup_single: extra active cycles=%0d expected 0", extra);
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_arrive();
        test_depart();
        test_both();
        test_done_held();
        test_alternate();
        test_reset_mid();
        test_depart_dup();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
